// File: rtl/mem_arbiter_if.sv
// Bus bundle between the memory arbiter, its two requesters and the shared memory.
// slave  : the arbiter's view (requests in, acks/read data/memory strobes out).
// master : the environment's view (requesters and memory model).
// Optional macro MEM_ARB_LOCK_EN adds the dma_lock request qualifier.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) ();
    // Control-path requester
    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic [DATA_WIDTH-1:0] cpu_rdata;
    logic                  cpu_ack;
    logic                  cpu_stall;

    // DMA / program-loader requester
    logic                  dma_req;
    logic                  dma_we;
    logic [ADDR_WIDTH-1:0] dma_addr;
    logic [DATA_WIDTH-1:0] dma_wdata;
    logic [DATA_WIDTH-1:0] dma_rdata;
    logic                  dma_ack;
`ifdef MEM_ARB_LOCK_EN
    logic                  dma_lock;
`endif

    // Shared memory
    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    logic                  owner_dma;

`ifdef MEM_ARB_LOCK_EN
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack, cpu_stall,
        input  dma_req, dma_we, dma_addr, dma_wdata, dma_lock,
        output dma_rdata, dma_ack,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output owner_dma
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack, cpu_stall,
        output dma_req, dma_we, dma_addr, dma_wdata, dma_lock,
        input  dma_rdata, dma_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  owner_dma
    );
`else
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack, cpu_stall,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_rdata, dma_ack,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output owner_dma
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack, cpu_stall,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_rdata, dma_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  owner_dma
    );
`endif

endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory between the control path and a
// DMA/program-loader port. Each access runs IDLE -> ACCESS (WAIT_CYCLES+1 cycles) -> DONE.
// Optional macro MEM_ARB_LOCK_EN: dma_lock lets DMA win every arbitration while it is set.
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic         clock,
    input  logic         reset,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StDone
    } state_e;

    localparam logic [3:0] WaitLast = 4'(WAIT_CYCLES);

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  owner_q, owner_d;           // 1 = DMA owns the access
    logic                  last_owner_q, last_owner_d; // 1 = DMA was served last
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_WIDTH-1:0] dma_rdata_q, dma_rdata_d;
    logic                  grant_dma;
    logic                  lock_win;

    // Locked DMA requests override the round-robin pointer.
`ifdef MEM_ARB_LOCK_EN
    assign lock_win = bus.dma_lock & bus.dma_req;
`else
    assign lock_win = 1'b0;
`endif

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= 4'd0;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;  // CPU wins the first tie
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cpu_rdata_q  <= '0;
            dma_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dma_rdata_q  <= dma_rdata_d;
        end
    end

    // Arbitration, access sequencing and output decode.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cpu_rdata_d  = cpu_rdata_q;
        dma_rdata_d  = dma_rdata_q;
        grant_dma    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.cpu_req || bus.dma_req) begin
                    if (lock_win) begin
                        grant_dma = 1'b1;
                    end else if (bus.cpu_req && bus.dma_req) begin
                        grant_dma = ~last_owner_q;
                    end else begin
                        grant_dma = bus.dma_req;
                    end
                    owner_d = grant_dma;
                    we_d    = grant_dma ? bus.dma_we    : bus.cpu_we;
                    addr_d  = grant_dma ? bus.dma_addr  : bus.cpu_addr;
                    wdata_d = grant_dma ? bus.dma_wdata : bus.cpu_wdata;
                    cnt_d   = 4'd0;
                    state_d = StAccess;
                end
            end
            StAccess: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == WaitLast) begin
                    // Writes leave the requester's read-data register untouched.
                    if (!we_q) begin
                        if (owner_q) begin
                            dma_rdata_d = bus.mem_rdata;
                        end else begin
                            cpu_rdata_d = bus.mem_rdata;
                        end
                    end
                    last_owner_d = owner_q;
                    state_d      = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        bus.mem_en    = (state_q == StAccess);
        // Single write strobe on the first access cycle only.
        bus.mem_we    = (state_q == StAccess) && (cnt_q == 4'd0) && we_q;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        bus.cpu_ack   = (state_q == StDone) && !owner_q;
        bus.dma_ack   = (state_q == StDone) && owner_q;
        bus.owner_dma = (state_q != StIdle) && owner_q;
        bus.cpu_rdata = cpu_rdata_q;
        bus.dma_rdata = dma_rdata_q;
        bus.cpu_stall = bus.cpu_req & ~bus.cpu_ack;
    end

endmodule
